// File: rtl/mdu_pipe_param.sv
// Parametrised multiply/divide unit with HI/LO pair for the execute stage.
// The operation is captured at launch; HI/LO are written on the edge the latency counter expires.
module mdu_pipe_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [2:0]       Op,
  input  logic             Start,
  input  logic             We,
  input  logic             HiLo,
  input  logic             Flush,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_LAT - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             mul_signed_c;
  logic             a_neg_c, b_neg_c;
  logic             div_launch_c;
  logic [PW-1:0]    a_ext_c, b_ext_c, prod_c, acc_c, res_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, q_mag_c, r_mag_c, quo_c, rem_c;

  // Product of the held operands, sign- or zero-extended to the full HI:LO width
  always_comb begin
    mul_signed_c = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext_c      = mul_signed_c ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext_c      = mul_signed_c ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c       = a_ext_c * b_ext_c;
    acc_c        = {hi_q, lo_q};
  end

  // Signed divide on magnitudes; most-negative / -1 falls out as most-negative, remainder 0
  always_comb begin
    a_neg_c = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg_c = (op_q == OP_DIV) && b_q[WIDTH-1];
    a_mag_c = a_neg_c ? -a_q : a_q;
    b_mag_c = b_neg_c ? -b_q : b_q;
    q_mag_c = (b_mag_c == '0) ? '0 : a_mag_c / b_mag_c;
    r_mag_c = (b_mag_c == '0) ? '0 : a_mag_c % b_mag_c;
    quo_c   = (a_neg_c ^ b_neg_c) ? -q_mag_c : q_mag_c;
    rem_c   = a_neg_c ? -r_mag_c : r_mag_c;
  end

  // Value written into {HI,LO} on completion
  always_comb begin
    res_c = prod_c;
    case (op_q)
      OP_MULT, OP_MULTU: res_c = prod_c;
      OP_DIV, OP_DIVU:   res_c = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem_c, quo_c};
      OP_MADD, OP_MADDU: res_c = acc_c + prod_c;
      OP_MSUB, OP_MSUBU: res_c = acc_c - prod_c;
    endcase
  end

  assign div_launch_c = (Op == OP_DIV) || (Op == OP_DIVU);

  // Next state: Flush beats completion; in IDLE Flush suppresses Start and We, Start beats We
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (Start) begin
            state_d = S_RUN;
            op_d    = Op;
            a_d     = D1;
            b_d     = D2;
            cnt_d   = div_launch_c ? CNT_DIV : CNT_MUL;
          end else if (We) begin
            if (HiLo) begin
              hi_d = D1;
            end else begin
              lo_d = D1;
            end
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          hi_d    = res_c[PW-1:WIDTH];
          lo_d    = res_c[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_pipe_param.sv
// Bench for mdu_pipe_param: a 32-bit default instance (directed) and a 16-bit instance (randomised),
// both checked every cycle against an arithmetic reference model.
module tb_mdu_pipe_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], start[2], we[2], hilo[2], flush[2];
  logic [2:0]  op[2];
  logic [31:0] d1[2], d2[2];
  logic        busy_o[2];
  logic [31:0] hi_o[2], lo_o[2];

  logic        busy32, busy16;
  logic [31:0] hi32, lo32;
  logic [15:0] hi16, lo16;

  int n_checks = 0;
  int n_errors = 0;

  mdu_pipe_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) u32 (
    .Clk(clk), .Rst(rst[0]), .D1(d1[0]), .D2(d2[0]), .Op(op[0]), .Start(start[0]),
    .We(we[0]), .HiLo(hilo[0]), .Flush(flush[0]), .Busy(busy32), .HI(hi32), .LO(lo32)
  );

  mdu_pipe_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(17)) u16 (
    .Clk(clk), .Rst(rst[1]), .D1(d1[1][15:0]), .D2(d2[1][15:0]), .Op(op[1]), .Start(start[1]),
    .We(we[1]), .HiLo(hilo[1]), .Flush(flush[1]), .Busy(busy16), .HI(hi16), .LO(lo16)
  );

  always_comb begin
    busy_o[0] = busy32;
    hi_o[0]   = hi32;
    lo_o[0]   = lo32;
    busy_o[1] = busy16;
    hi_o[1]   = {16'h0, hi16};
    lo_o[1]   = {16'h0, lo16};
  end

  // ---------------- reference model ----------------
  function automatic int wid(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int lat_of(input int i, input logic [2:0] o);
    if (o == 3'd2 || o == 3'd3) return (i == 0) ? 10 : 17;
    return (i == 0) ? 5 : 1;
  endfunction

  function automatic logic [63:0] wmask64(input int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // {HI,LO} packed as HI<<w | LO
  function automatic logic [63:0] model_result(input int w, input logic [2:0] o,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] acc);
    logic [63:0] wm, ua, ub, p, r, mask;
    longint sa, sb, q, m;
    wm   = wmask64(w);
    ua   = {32'h0, a} & wm;
    ub   = {32'h0, b} & wm;
    sa   = longint'(ua << (64 - w)) >>> (64 - w);
    sb   = longint'(ub << (64 - w)) >>> (64 - w);
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (o == 3'd0 || o == 3'd4 || o == 3'd6) p = 64'(sa * sb);
    else p = ua * ub;
    r = p;
    case (o)
      3'd0, 3'd1: r = p;
      3'd4, 3'd5: r = acc + p;
      3'd6, 3'd7: r = acc - p;
      3'd2: begin
        if (ub == 64'd0) r = (ua << w) | wm;
        else begin
          q = sa / sb;
          m = sa % sb;
          r = ((64'(m) & wm) << w) | (64'(q) & wm);
        end
      end
      3'd3: begin
        if (ub == 64'd0) r = (ua << w) | wm;
        else r = ((ua % ub) << w) | (ua / ub);
      end
    endcase
    return r & mask;
  endfunction

  bit          m_ok[2], m_busy[2];
  int          m_rem[2];
  logic [2:0]  m_op[2];
  logic [31:0] m_a[2], m_b[2], m_hi[2], m_lo[2];
  logic [63:0] m_acc[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          w;
      logic [63:0] r, wm;
      w  = wid(i);
      wm = wmask64(w);
      if (rst[i]) begin
        m_ok[i] = 1'b1; m_busy[i] = 1'b0; m_hi[i] = 32'h0; m_lo[i] = 32'h0;
      end else if (m_busy[i]) begin
        if (flush[i]) m_busy[i] = 1'b0;
        else begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            r = model_result(w, m_op[i], m_a[i], m_b[i], m_acc[i]);
            m_hi[i]   = 32'((r >> w) & wm);
            m_lo[i]   = 32'(r & wm);
            m_busy[i] = 1'b0;
          end
        end
      end else if (!flush[i]) begin
        if (start[i]) begin
          m_op[i]   = op[i];
          m_a[i]    = d1[i];
          m_b[i]    = d2[i];
          m_acc[i]  = ({32'h0, m_hi[i]} << w) | {32'h0, m_lo[i]};
          m_rem[i]  = lat_of(i, op[i]);
          m_busy[i] = 1'b1;
        end else if (we[i]) begin
          if (hilo[i]) m_hi[i] = 32'({32'h0, d1[i]} & wm);
          else m_lo[i] = 32'({32'h0, d1[i]} & wm);
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_ok[i]) begin
        n_checks += 3;
        if (busy_o[i] !== m_busy[i]) begin
          n_errors++;
          $display("FAIL dut%0d busy @%0t: got %b expected %b", i, $time, busy_o[i], m_busy[i]);
        end
        if (hi_o[i] !== m_hi[i]) begin
          n_errors++;
          $display("FAIL dut%0d HI @%0t: got %h expected %h", i, $time, hi_o[i], m_hi[i]);
        end
        if (lo_o[i] !== m_lo[i]) begin
          n_errors++;
          $display("FAIL dut%0d LO @%0t: got %h expected %h", i, $time, lo_o[i], m_lo[i]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // kind: 0 none, 1 We, 2 Start, 3 Flush, 4 Rst -- injected so the edge t0+k samples it
  task automatic run_op(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int k, input int kind, output int n);
    op[i] = o; d1[i] = a; d2[i] = b; start[i] = 1'b1;
    tick();
    start[i] = 1'b0; we[i] = 1'b0; flush[i] = 1'b0;
    op[i] = 3'($urandom); d1[i] = $urandom; d2[i] = $urandom;
    n = 0;
    while (busy_o[i] === 1'b1 && n < 64) begin
      n++;
      if (n == k) begin
        case (kind)
          1: begin we[i] = 1'b1; hilo[i] = 1'b1; d1[i] = $urandom; end
          2: begin start[i] = 1'b1; op[i] = 3'($urandom); end
          3: flush[i] = 1'b1;
          4: rst[i] = 1'b1;
          default: ;
        endcase
      end
      tick();
      start[i] = 1'b0; we[i] = 1'b0; flush[i] = 1'b0; rst[i] = 1'b0;
    end
    if (n >= 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL dut%0d busy timeout: got %0d cycles expected completion", i, n);
    end
  endtask

  task automatic chk_op(input string name, input int exp_n, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    chk({name, " busy cycles"}, 32'(n), 32'(exp_n));
    chk({name, " HI"}, hi_o[0], eh);
    chk({name, " LO"}, lo_o[0], el);
    chk({name, " model HI"}, m_hi[0], eh);
    chk({name, " model LO"}, lo_o[0] == el ? m_lo[0] : m_lo[0], el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF;
      2: return 32'h8000;
      3: return 32'h1;
      4: return 32'h7FFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of stimulus expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, kind, ev, lat;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 2; i++) begin
      m_ok[i] = 1'b0; m_busy[i] = 1'b0; m_rem[i] = 0;
      rst[i] = 1'b1; start[i] = 1'b0; we[i] = 1'b0; hilo[i] = 1'b0; flush[i] = 1'b0;
      op[i] = 3'd0; d1[i] = 32'h0; d2[i] = 32'h0;
    end
    tick();
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("reset busy", 32'(busy_o[0]), 32'h0);
    chk("reset HI", hi_o[0], 32'h0);
    chk("reset LO", lo_o[0], 32'h0);

    // 32-bit directed sequence
    run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, n);
    chk_op("mult -2*3", 5, n, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
    chk_op("multu", 5, n, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(0, 3'd5, 32'd1, 32'd1, 0, 0, n);
    chk_op("maddu", 5, n, 32'hFFFF_FFFE, 32'h0000_0002);
    run_op(0, 3'd6, 32'd2, 32'd1, 0, 0, n);
    chk_op("msub", 5, n, 32'hFFFF_FFFE, 32'h0000_0000);
    run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
    chk_op("div -7/2", 10, n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(0, 3'd3, 32'd7, 32'd0, 0, 0, n);
    chk_op("divu by zero", 10, n, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
    chk_op("div overflow", 10, n, 32'h0000_0000, 32'h8000_0000);

    we[0] = 1'b1; hilo[0] = 1'b1; d1[0] = 32'h1234;
    tick();
    hilo[0] = 1'b0; d1[0] = 32'h5678;
    tick();
    we[0] = 1'b0;
    chk("mthi/mtlo busy", 32'(busy_o[0]), 32'h0);
    chk("mthi HI", hi_o[0], 32'h0000_1234);
    chk("mtlo LO", lo_o[0], 32'h0000_5678);

    run_op(0, 3'd2, 32'd100, 32'd7, 3, 1, n);
    chk_op("div with We mid-run", 10, n, 32'h0000_0002, 32'h0000_000E);
    run_op(0, 3'd0, 32'd6, 32'd7, 2, 2, n);
    chk_op("mult with Start mid-run", 5, n, 32'h0, 32'h0000_002A);
    we[0] = 1'b1; hilo[0] = 1'b0;
    run_op(0, 3'd4, 32'd3, 32'd3, 0, 0, n);
    chk_op("madd with We at launch", 5, n, 32'h0, 32'h0000_0033);
    run_op(0, 3'd0, 32'd6, 32'd7, 3, 3, n);
    chk_op("flush at cycle 3", 3, n, 32'h0, 32'h0000_0033);
    run_op(0, 3'd0, 32'd3, 32'd3, 5, 3, n);
    chk_op("flush on completion", 5, n, 32'h0, 32'h0000_0033);

    flush[0] = 1'b1; start[0] = 1'b1; op[0] = 3'd0; d1[0] = 32'd1; d2[0] = 32'd1;
    tick();
    flush[0] = 1'b0; start[0] = 1'b0;
    chk("flush suppresses start", 32'(busy_o[0]), 32'h0);
    flush[0] = 1'b1; we[0] = 1'b1; hilo[0] = 1'b1; d1[0] = 32'hFF;
    tick();
    flush[0] = 1'b0; we[0] = 1'b0;
    chk("flush suppresses We HI", hi_o[0], 32'h0);

    run_op(0, 3'd2, 32'd100, 32'd7, 2, 4, n);
    chk_op("rst mid div", 2, n, 32'h0, 32'h0);

    // 16-bit randomised sweep, back-to-back launches
    for (int t = 0; t < 1000; t++) begin
      o    = 3'($urandom);
      a    = pick();
      b    = pick();
      lat  = lat_of(1, o);
      ev   = $urandom_range(0, 11);
      kind = 0;
      k    = 0;
      case (ev)
        0, 1: kind = 3;
        2, 3: kind = 2;
        5:    kind = 1;
        6:    kind = 4;
        default: ;
      endcase
      if (kind != 0) k = $urandom_range(1, lat);
      if (ev == 4) begin
        we[1] = 1'b1; hilo[1] = 1'($urandom); d1[1] = $urandom;
        tick();
        we[1] = 1'b0;
      end
      run_op(1, o, a, b, k, kind, n);
      chk("random busy cycles", 32'(n), (kind == 3 || kind == 4) ? 32'(k) : 32'(lat));
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
